// File: rtl/mc_cpu_pkg.sv
// Shared constants for the multi-cycle MIPS-subset core: opcodes, functs, FSM states, ALU ops.
// MC_CPU_SHIFT_EN adds the sll/srl R-type functs to the legal instruction set.
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6
  } alu_op_e;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
`ifdef MC_CPU_SHIFT_EN
          FN_SLL, FN_SRL: ok = 1'b1;
`else
          FN_SLL, FN_SRL: ok = 1'b0;
`endif
          default: ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational 32-bit ALU; shifts operate on the B operand by shamt.
module mc_cpu_alu
  import mc_cpu_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {31'b0, (a_s < b_s)};
      ALU_SLL: result_o = b_i << shamt_i;
      ALU_SRL: result_o = b_i >> shamt_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM with a req/ready memory port.
// Define MC_CPU_SHIFT_EN to enable sll/srl; otherwise those functs halt the core.
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int NREGS    = 32
) (
  input  logic            clk,
  input  logic            clr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ready,
  output logic            instr_done,
  output logic            halted
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       ir_q, a_q, b_q, res_q;
  logic [31:0]       rf_q [NREGS];
  logic              mem_req_q, mem_we_q, instr_done_q, halted_q;
  logic [PC_W-1:0]   mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic [5:0]        op_d, fn_d;
  logic [RIDX_W-1:0] rs_d, rt_d, rd_d, wb_idx_d;
  logic [31:0]       simm_d, rs_val_d, rt_val_d, alu_b_d, alu_res_d;
  logic              alu_zero_d;
  alu_op_e           alu_op_d;
  logic [PC_W-1:0]   pc_br_d, pc_j_d;

  assign op_d     = ir_q[31:26];
  assign fn_d     = ir_q[5:0];
  assign rs_d     = ir_q[21 +: RIDX_W];
  assign rt_d     = ir_q[16 +: RIDX_W];
  assign rd_d     = ir_q[11 +: RIDX_W];
  assign simm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rs_val_d = (rs_d == '0) ? 32'd0 : rf_q[rs_d];
  assign rt_val_d = (rt_d == '0) ? 32'd0 : rf_q[rt_d];
  assign wb_idx_d = (op_d == OP_RTYPE) ? rd_d : rt_d;

  // pc_q already holds PC+4 by the time EXEC computes branch/jump targets
  assign pc_br_d  = pc_q + PC_W'(simm_d << 2);
  assign pc_j_d   = PC_W'({4'(32'(pc_q) >> 28), ir_q[25:0], 2'b00});

  always_comb begin
    alu_op_d = ALU_ADD;
    alu_b_d  = simm_d;
    if (op_d == OP_RTYPE) begin
      alu_b_d = b_q;
      case (fn_d)
        FN_SUB:  alu_op_d = ALU_SUB;
        FN_AND:  alu_op_d = ALU_AND;
        FN_OR:   alu_op_d = ALU_OR;
        FN_SLT:  alu_op_d = ALU_SLT;
`ifdef MC_CPU_SHIFT_EN
        FN_SLL:  alu_op_d = ALU_SLL;
        FN_SRL:  alu_op_d = ALU_SRL;
`endif
        default: alu_op_d = ALU_ADD;
      endcase
    end else if (op_d == OP_BEQ) begin
      alu_op_d = ALU_SUB;
      alu_b_d  = b_q;
    end
  end

  mc_cpu_alu u_alu (
    .op_i     (alu_op_d),
    .a_i      (a_q),
    .b_i      (alu_b_d),
    .shamt_i  (ir_q[10:6]),
    .result_o (alu_res_d),
    .zero_o   (alu_zero_d)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_FETCH;
      pc_q         <= PC_W'(RESET_PC);
      ir_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      instr_done_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ready) begin
            mem_req_q <= 1'b0;
            ir_q      <= mem_rdata;
            pc_q      <= pc_q + PC_W'(4);
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= rs_val_d;
          b_q <= rt_val_d;
          if (is_legal(op_d, fn_d)) begin
            state_q <= S_EXEC;
          end else begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_EXEC: begin
          res_q <= alu_res_d;
          case (op_d)
            OP_LW, OP_SW: state_q <= S_MEM;
            OP_BEQ: begin
              if (alu_zero_d) pc_q <= pc_br_d;
              instr_done_q <= 1'b1;
              state_q      <= S_FETCH;
            end
            OP_J: begin
              pc_q         <= pc_j_d;
              instr_done_q <= 1'b1;
              state_q      <= S_FETCH;
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= (op_d == OP_SW);
            mem_addr_q <= {res_q[PC_W-1:2], 2'b00};
            if (op_d == OP_SW) mem_wdata_q <= b_q;
          end else if (mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (op_d == OP_SW) begin
              instr_done_q <= 1'b1;
              state_q      <= S_FETCH;
            end else begin
              res_q   <= mem_rdata;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_idx_d != '0) rf_q[wb_idx_d] <= res_q;
          instr_done_q <= 1'b1;
          state_q      <= S_FETCH;
        end
        default: begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign instr_done = instr_done_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: behavioural memory with wait states, write scoreboard, ALU vector table.
module tb_mc_cpu_core;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mem_req, mem_we, instr_done, halted;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mc_cpu_core #(.PC_W(8), .RESET_PC(0), .NREGS(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .instr_done (instr_done),
    .halted     (halted)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  fn;
    logic [31:0] exp;
  } alu_vec_t;

  logic [31:0] mem [64];
  int          delay, wcnt, ecnt, stab_viol, errors, checks, nreq, ndone, found;
  bit          txn_act;
  logic [7:0]  s_addr;
  logic        s_we;
  logic [31:0] s_wd;
  logic [39:0] wr_log[$];
  logic [39:0] exp_wr[$];
  logic [7:0]  rd_log[$];
  int          done_log[$];
  alu_vec_t    vt[10];

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: memory responder plus edge counter, evaluated at the falling edge
  task automatic tick();
    @(negedge clk);
    if (clr) ecnt = 0;
    else ecnt++;
    if (mem_req === 1'b1) begin
      if (!txn_act) begin
        txn_act = 1'b1; wcnt = 0;
        s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
      end else if (mem_addr !== s_addr || mem_we !== s_we || (s_we && mem_wdata !== s_wd)) begin
        stab_viol++;
      end
      if (wcnt >= delay) begin
        mem_ready = 1'b1;
        txn_act   = 1'b0;
        if (mem_we) begin
          mem[mem_addr[7:2]] = mem_wdata;
          wr_log.push_back({mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr[7:2]];
          rd_log.push_back(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      txn_act   = 1'b0;
    end
    if (instr_done === 1'b1) done_log.push_back(ecnt);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = HALT_W;
  endtask

  task automatic start();
    clr = 1'b1;
    tick();
    tick();
    wr_log.delete(); rd_log.delete(); done_log.delete();
    stab_viol = 0;
    clr = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int max);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk({name, "_halt_reached"}, 64'(halted), 64'd1);
  endtask

  task automatic check_writes(input string name);
    chk({name, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    while (exp_wr.size() > 0 && wr_log.size() > 0)
      chk({name, "_wr"}, 64'(wr_log.pop_front()), 64'(exp_wr.pop_front()));
    exp_wr.delete();
  endtask

  function automatic int rd_at(int i);
    return (i < rd_log.size()) ? int'(rd_log[i]) : -1;
  endfunction

  function automatic int done_at(int i);
    return (i < done_log.size()) ? done_log[i] : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; delay = 0; ecnt = 0; stab_viol = 0; txn_act = 1'b0; wcnt = 0;
    vt[0] = '{"add",  16'h0005, 16'hFFFD, 6'h20, 32'h0000_0002};
    vt[1] = '{"sub",  16'h0005, 16'h0007, 6'h22, 32'hFFFF_FFFE};
    vt[2] = '{"and",  16'h7F0F, 16'h0FF0, 6'h24, 32'h0000_0F00};
    vt[3] = '{"or",   16'h00F0, 16'h0F00, 6'h25, 32'h0000_0FF0};
    vt[4] = '{"sltn", 16'hFFFF, 16'h0001, 6'h2A, 32'h0000_0001};
    vt[5] = '{"sltp", 16'h0001, 16'hFFFF, 6'h2A, 32'h0000_0000};
    vt[6] = '{"addw", 16'h7FFF, 16'h7FFF, 6'h20, 32'h0000_FFFE};
    vt[7] = '{"subm", 16'h0000, 16'h8000, 6'h22, 32'h0000_8000};
    vt[8] = '{"sltb", 16'hFFFB, 16'hFFFD, 6'h2A, 32'h0000_0001};
    vt[9] = '{"ands", 16'h8000, 16'hFFFF, 6'h24, 32'hFFFF_8000};

    // Reset state and first request
    clear_mem();
    tick(); tick();
    chk("rst_mem_req",    64'(mem_req),    64'd0);
    chk("rst_mem_we",     64'(mem_we),     64'd0);
    chk("rst_mem_addr",   64'(mem_addr),   64'd0);
    chk("rst_mem_wdata",  64'(mem_wdata),  64'd0);
    chk("rst_instr_done", 64'(instr_done), 64'd0);
    chk("rst_halted",     64'(halted),     64'd0);
    clr = 1'b0;
    tick();
    chk("first_req",      64'(mem_req),  64'd1);
    chk("first_req_addr", 64'(mem_addr), 64'd0);
    chk("first_req_we",   64'(mem_we),   64'd0);

    // addi/addi/add, then store R3 to expose it; latency via retire edges
    clear_mem();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h08, 0, 2, 16'hFFFD);
    mem[2] = enc_r(1, 2, 3, 0, 6'h20);
    mem[3] = enc_i(6'h2B, 0, 3, 16'h00F0);
    exp_wr.push_back({8'hF0, 32'd2});
    start();
    run_to_halt("basic", 200);
    check_writes("basic");
    chk("basic_pc_after3", 64'(rd_at(3)), 64'd12);
    chk("basic_done_cnt", 64'(done_log.size()), 64'd4);
    chk("lat_addi",  64'(done_at(0)), 64'd5);
    chk("lat_addi2", 64'(done_at(1)), 64'd10);
    chk("lat_add",   64'(done_at(2)), 64'd15);
    chk("lat_sw",    64'(done_at(3)), 64'd21);

    // Writes to $0 are discarded
    clear_mem();
    mem[0] = enc_i(6'h08, 0, 0, 16'd9);
    mem[1] = enc_i(6'h2B, 0, 0, 16'h00F8);
    exp_wr.push_back({8'hF8, 32'd0});
    start();
    run_to_halt("r0", 200);
    check_writes("r0");

    // ALU vector table
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      mem[0] = enc_i(6'h08, 0, 1, vt[v].a);
      mem[1] = enc_i(6'h08, 0, 2, vt[v].b);
      mem[2] = enc_r(1, 2, 3, 0, vt[v].fn);
      mem[3] = enc_i(6'h2B, 0, 3, 16'h00F0);
      exp_wr.push_back({8'hF0, vt[v].exp});
      start();
      run_to_halt(vt[v].name, 200);
      check_writes(vt[v].name);
    end

    // sw/lw with three wait states, program relocated to 0x80
    clear_mem();
    mem[0]  = enc_j(26'h20);
    mem[32] = enc_i(6'h08, 0, 3, 16'd2);
    mem[33] = enc_i(6'h2B, 0, 3, 16'd16);
    mem[34] = enc_i(6'h23, 0, 4, 16'd16);
    mem[35] = enc_i(6'h2B, 0, 4, 16'h00F4);
    exp_wr.push_back({8'd16, 32'd2});
    exp_wr.push_back({8'hF4, 32'd2});
    delay = 3;
    start();
    run_to_halt("memwait", 400);
    check_writes("memwait");
    chk("memwait_stable", 64'(stab_viol), 64'd0);
    chk("memwait_done_cnt", 64'(done_log.size()), 64'd5);
    found = 0;
    foreach (rd_log[i]) if (rd_log[i] == 8'd16) found = 1;
    chk("memwait_lw_addr", 64'(found), 64'd1);
    delay = 0;

    // beq self-loop at 0x20
    clear_mem();
    mem[0] = enc_j(26'h08);
    mem[8] = enc_i(6'h04, 1, 1, 16'hFFFF);
    start();
    repeat (40) tick();
    chk("loop_halted", 64'(halted), 64'd0);
    chk("loop_f1", 64'(rd_at(1)), 64'h20);
    chk("loop_f2", 64'(rd_at(2)), 64'h20);
    chk("loop_f3", 64'(rd_at(3)), 64'h20);
    chk("lat_j",   64'(done_at(0)), 64'd4);
    chk("lat_beq", 64'(done_at(1)), 64'd8);
    chk("lat_beq2", 64'(done_at(2)), 64'd12);

    // beq not taken, then j 0x10
    clear_mem();
    mem[0]  = enc_i(6'h08, 0, 1, 16'd1);
    mem[1]  = enc_j(26'h08);
    mem[8]  = enc_i(6'h04, 1, 0, 16'hFFFF);
    mem[9]  = enc_j(26'h10);
    start();
    run_to_halt("branch", 200);
    chk("branch_f2", 64'(rd_at(2)), 64'h20);
    chk("branch_f3", 64'(rd_at(3)), 64'h24);
    chk("branch_f4", 64'(rd_at(4)), 64'h40);
    chk("branch_done_cnt", 64'(done_log.size()), 64'd4);

    // Illegal opcode 0x3F
    clear_mem();
    start();
    tick(); tick();
    chk("ill_halted_early", 64'(halted), 64'd0);
    tick();
    chk("ill_halted", 64'(halted), 64'd1);
    nreq = 0; ndone = 0;
    repeat (20) begin
      tick();
      if (mem_req !== 1'b0) nreq++;
      if (instr_done !== 1'b0) ndone++;
    end
    chk("ill_no_req", 64'(nreq), 64'd0);
    chk("ill_no_done", 64'(ndone + done_log.size()), 64'd0);
    clr = 1'b1;
    tick();
    chk("ill_clr_halted", 64'(halted), 64'd0);

    // clr on the same edge as the lw's ready, mid-transaction
    clear_mem();
    mem[0] = enc_i(6'h23, 0, 4, 16'd16);
    mem[4] = 32'h0000_0055;
    delay = 2;
    start();
    found = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      tick();
      if (mem_ready === 1'b1 && mem_we === 1'b0 && mem_addr == 8'd16) found = 1;
    end
    chk("clr_lw_seen", 64'(found), 64'd1);
    clr = 1'b1;
    tick();
    chk("clr_mem_req", 64'(mem_req), 64'd0);
    chk("clr_mem_addr", 64'(mem_addr), 64'd0);
    chk("clr_done", 64'(instr_done), 64'd0);
    mem[0] = enc_i(6'h2B, 0, 4, 16'h00F0);
    mem[1] = HALT_W;
    exp_wr.push_back({8'hF0, 32'd0});
    start();
    run_to_halt("clr", 200);
    chk("clr_restart_pc", 64'(rd_at(0)), 64'd0);
    check_writes("clr");
    delay = 0;

    // Shift option
    clear_mem();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_r(0, 1, 5, 4, 6'h00);
    mem[2] = enc_i(6'h2B, 0, 5, 16'h00F0);
`ifdef MC_CPU_SHIFT_EN
    mem[3] = enc_i(6'h08, 0, 2, 16'hFFF0);
    mem[4] = enc_r(0, 2, 6, 28, 6'h02);
    mem[5] = enc_i(6'h2B, 0, 6, 16'h00F4);
    exp_wr.push_back({8'hF0, 32'd80});
    exp_wr.push_back({8'hF4, 32'h0000_000F});
    start();
    run_to_halt("shift", 300);
    check_writes("shift");
    chk("shift_done_cnt", 64'(done_log.size()), 64'd6);
`else
    start();
    run_to_halt("shift", 300);
    check_writes("shift");
    chk("shift_done_cnt", 64'(done_log.size()), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_cpu_core.md
MC_CPU_CORE -- requirements
Module: mc_cpu_core

Interface
REQ-001 Parameter PC_W, default 8, byte-address width of PC and memory bus.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter NREGS, default 32, register-file depth (power of 2, 2..32); register index = low log2(NREGS) bits of the rs/rt/rd fields.
REQ-004 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; clr  in  1  synchronous active-high reset.
REQ-005 mem_req  out  1  memory transaction request.
REQ-006 mem_we  out  1  1=write (sw), 0=read (fetch/lw).
REQ-007 mem_addr  out  PC_W  byte address, word-aligned.
REQ-008 mem_wdata  out  32  store data.
REQ-009 mem_rdata  in  32  read data, valid when mem_ready=1.
REQ-010 mem_ready  in  1  completes the current request.
REQ-011 instr_done  out  1  one-cycle pulse per retired instruction.
REQ-012 halted  out  1  core stopped on illegal opcode/funct.

Function
REQ-013 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; transitions occur only on the rising edge of clk.
REQ-014 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready=1 latch IR=mem_rdata, PC<=PC+4 (mod 2^PC_W), go DECODE.
REQ-015 Handshake: while mem_req=1, mem_addr/mem_we/mem_wdata held stable until mem_ready sampled 1; mem_req deasserts the cycle after; mem_ready while mem_req=0 ignored; unlimited wait states.
REQ-016 DECODE: latch A=R[rs], B=R[rt]; illegal opcode or R-type funct -> HALT; else EXEC.
REQ-017 Supported: R-type (op 0x00) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02.
REQ-018 EXEC: R-type/addi -> ALU result latched, go WB; lw/sw -> address A+signext(imm16) truncated to PC_W, go MEM; beq -> if A==B PC<=PC+(signext(imm16)<<2), retire, go FETCH; j -> PC<={PC[PC_W-1:28-or-top], imm26<<2} truncated to PC_W, retire, go FETCH.
REQ-019 Arithmetic modulo 2^32; overflow ignored; slt signed; addi sign-extends imm16.
REQ-020 MEM: lw issues read, latches mem_rdata, go WB; sw issues write with mem_wdata=B, retires on mem_ready, go FETCH.
REQ-021 WB: write R[rd] (R-type) or R[rt] (addi/lw); retire; go FETCH.
REQ-022 Register 0 reads 0; writes to register 0 discarded.
REQ-023 instr_done pulses exactly in the cycle following the retiring edge for each non-halting instruction.
REQ-024 Zero-wait latencies clk-to-retire: R-type/addi 5, lw 7, sw 6, beq/j 4 cycles (FETCH includes 1 request + 1 ready cycle).
REQ-025 HALT: halted=1, mem_req=0, no register/PC change, exit only via clr.

Reset
REQ-026 clr=1 at an edge: state FETCH, PC=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_done=0, halted=0, IR=0; register file cleared to 0.
REQ-027 clr overrides any in-flight transaction, including mid-wait; pending mem_ready in the same cycle ignored.
REQ-028 First mem_req asserted the cycle after clr deasserts.

Configuration
REQ-029 Macro MC_CPU_SHIFT_EN defined: R-type sll (funct 0x00, R[rd]=B<<shamt) and srl (0x02, logical) supported, latency as R-type.
REQ-030 Macro MC_CPU_SHIFT_EN undefined: funct 0x00/0x02 are illegal -> HALT (note: instruction word 0x00000000 then halts).

Structure
REQ-031 Package mc_cpu_pkg holds opcode/funct constants, FSM state encoding, 4-bit ALU op codes.
REQ-032 Sub-module mc_cpu_alu (combinational, 32-bit, ALU op + shamt in, result + zero out); register file and FSM inline.

Verification
REQ-033 clr, zero-wait memory with addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> R3=2, three instr_done pulses, PC=12.
REQ-034 sw $3,16($0) then lw $4,16($0) with mem_ready delayed 3 cycles each -> write addr 16 data 2, R4=2, addr/wdata stable during wait.
REQ-035 beq $1,$1,-1 at PC=0x20 -> PC=0x20 loops; beq with unequal -> PC=0x24; j 0x10 -> PC=0x40.
REQ-036 Opcode 0x3F -> halted=1 after DECODE, mem_req stays 0 for 20 cycles, no instr_done.
REQ-037 clr asserted during lw MEM wait -> next cycle mem_req=0, PC=RESET_PC, R4 unchanged-by-load (0).
REQ-038 With MC_CPU_SHIFT_EN: sll $5,$1,4 with R1=5 -> R5=80; without: same word -> halted=1.
